nsum_dispatch: RTL and testbench

- Upstream feeder and result collector for the NSum triangular-sum stage (sum of 1..N, 3-bit N, 4-bit sum).
- Queues incoming N requests in a small FIFO and issues them to NSum one at a time as a single-cycle N_valid pulse.
- Waits for NSum's sum_valid, captures the result, and presents it on a valid/ready result port.
- Resolves the cases NSum cannot handle: N=0 produces no completion from NSum, and N≥6 overflows its 4-bit sum.

---
 rtl/nsum_dispatch.sv | 139 +++++++++++++
 tb/tb_nsum_dispatch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nsum_dispatch.sv
// nsum_dispatch: request FIFO and sequencer that feeds the NSum stage one job at a time
// and returns each sum, with overflow/timeout flags, on a valid/ready result port.
module nsum_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] N,
  output logic       N_valid,
  input  logic [3:0] sum,
  input  logic       sum_valid,
  output logic [3:0] res_sum,
  output logic [2:0] res_n,
  output logic       res_ovf,
  output logic       res_err,
  output logic       res_valid,
  input  logic       res_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DEPTH:0] C_FULL = (DEPTH + 1)'(DEPTH);
  localparam logic [CW-1:0]  C_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t r_state, w_next;

  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [DEPTH:0] r_count;
  logic [2:0]    r_job;
  logic [2:0]    r_n;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_resSum;
  logic [2:0]    r_resN;
  logic          r_resOvf, r_resErr;
  logic [2:0]    w_head;
  logic          w_push, w_pop, w_empty, w_timeout;

  assign w_empty   = (r_count == '0);
  assign in_ready  = (r_count != C_FULL);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_head    = r_mem[r_rptr];
  assign w_timeout = (r_cnt == C_LAST);

  assign N         = r_n;
  assign N_valid   = (r_state == ISSUE);
  assign res_valid = (r_state == HOLD);
  assign res_sum   = r_resSum;
  assign res_n     = r_resN;
  assign res_ovf   = r_resOvf;
  assign res_err   = r_resErr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (DEPTH + 1)'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - (DEPTH + 1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (!w_empty) w_next = (w_head == 3'd0) ? HOLD : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (sum_valid || w_timeout) w_next = HOLD;
      HOLD:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // N=0 completes locally because NSum never signals a result for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_job    <= '0;
      r_n      <= '0;
      r_cnt    <= '0;
      r_resSum <= '0;
      r_resN   <= '0;
      r_resOvf <= 1'b0;
      r_resErr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_job <= w_head;
            if (w_head == 3'd0) begin
              r_resSum <= '0;
              r_resN   <= '0;
              r_resOvf <= 1'b0;
              r_resErr <= 1'b0;
            end else begin
              r_n <= w_head;
            end
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (sum_valid) begin
            r_resSum <= sum;
            r_resN   <= r_job;
            r_resOvf <= (r_job >= 3'd6);
            r_resErr <= 1'b0;
          end else if (w_timeout) begin
            r_resSum <= '0;
            r_resN   <= r_job;
            r_resOvf <= 1'b0;
            r_resErr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nsum_dispatch.sv
// tb_nsum_dispatch: directed requests against a behavioural NSum model; expected results
// are queued at issue time and checked by an independent monitor on each result handshake.
module tb_nsum_dispatch;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] in_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] N;
  logic       N_valid;
  logic [3:0] sum;
  logic       sum_valid;
  logic [3:0] res_sum;
  logic [2:0] res_n;
  logic       res_ovf;
  logic       res_err;
  logic       res_valid;
  logic       res_ready;

  typedef struct packed {
    logic [3:0] s;
    logic [2:0] n;
    logic       ovf;
    logic       err;
  } res_t;

  res_t       expQ[$];
  logic [2:0] issueQ[$];
  res_t       mExp;
  logic [2:0] mN;
  int         vectors = 0;
  int         miscompares = 0;
  bit         stubDead = 1'b0;

  // NSum stand-in: result N+1 edges after the start pulse, then one wrap re-pulse 8 later.
  logic [2:0] mdlN = '0;
  logic [3:0] mdlSum = '0;
  logic       mdlSv = 1'b0;
  logic       mdlWrap = 1'b0;
  int         mdlCnt = 0;

  assign sum       = mdlSum;
  assign sum_valid = mdlSv;

  always #5 clk = ~clk;

  nsum_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_n(in_n), .in_valid(in_valid), .in_ready(in_ready),
    .N(N), .N_valid(N_valid), .sum(sum), .sum_valid(sum_valid),
    .res_sum(res_sum), .res_n(res_n), .res_ovf(res_ovf), .res_err(res_err),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  function automatic logic [3:0] triSum(input logic [2:0] n);
    int acc;
    acc = 0;
    for (int k = 1; k <= int'(n); k++) acc += k;
    return 4'(acc);
  endfunction

  always @(posedge clk) begin
    mdlSv <= 1'b0;
    if (N_valid) begin
      mdlN    <= N;
      mdlCnt  <= int'(N) + 1;
      mdlWrap <= 1'b0;
    end else if (mdlCnt > 0) begin
      mdlCnt <= mdlCnt - 1;
      if (mdlCnt == 1) begin
        if (!stubDead) begin
          mdlSv  <= 1'b1;
          mdlSum <= triSum(mdlN);
        end
        if (!mdlWrap) begin
          mdlCnt  <= 8;
          mdlWrap <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake and every start pulse is matched against its queue.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_result: got sum=%0d n=%0d ovf=%0b err=%0b, expected none",
                 res_sum, res_n, res_ovf, res_err);
      end else begin
        mExp = expQ.pop_front();
        checkOutput("result", 32'({res_sum, res_n, res_ovf, res_err}), 32'(mExp));
      end
    end
    if (!rst && N_valid) begin
      if (issueQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_issue: got N_valid with N=%0d, expected none", N);
      end else begin
        mN = issueQ.pop_front();
        checkOutput("issue_n", 32'(N), 32'(mN));
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] n, input logic [3:0] s,
                               input logic ovf, input logic err);
    int guard;
    res_t e;
    guard = 0;
    in_n = n;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL push_timeout: got in_ready=0 for %0d cycles, expected acceptance", guard);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.s = s;
    e.n = n;
    e.ovf = ovf;
    e.err = err;
    expQ.push_back(e);
    if (n != 3'd0) issueQ.push_back(n);
  endtask

  task automatic waitSignal(input string name, input int limit, input bit wantValid);
    int c;
    c = 0;
    while (((wantValid ? res_valid : N_valid) !== 1'b1) && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= limit) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got no pulse in %0d cycles, expected one", name, limit);
    end
  endtask

  task automatic waitDrain(input int limit);
    int c;
    c = 0;
    while ((expQ.size() != 0 || issueQ.size() != 0) && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= limit) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d results pending, expected 0", expQ.size());
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    in_n = '0;
    in_valid = 1'b0;
    res_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_N", 32'(N), 32'd0);
    checkOutput("rst_N_valid", 32'(N_valid), 32'd0);
    checkOutput("rst_res", 32'({res_valid, res_sum, res_n, res_ovf, res_err}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // N=4 held in HOLD for 10 cycles; the model's wrap re-pulse lands inside this window.
    applyStimulus(3'd4, 4'd10, 1'b0, 1'b0);
    waitSignal("n4_res_valid", 30, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_res", 32'({res_valid, res_sum, res_n, res_ovf, res_err}),
                  32'({1'b1, 4'd10, 3'd4, 1'b0, 1'b0}));
      checkOutput("hold_no_issue", 32'(N_valid), 32'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Fill the FIFO behind a stalled job, then release and drain in order.
    applyStimulus(3'd1, 4'd1, 1'b0, 1'b0);
    applyStimulus(3'd2, 4'd3, 1'b0, 1'b0);
    applyStimulus(3'd3, 4'd6, 1'b0, 1'b0);
    applyStimulus(3'd5, 4'd15, 1'b0, 1'b0);
    applyStimulus(3'd6, 4'd5, 1'b1, 1'b0);
    checkOutput("fifo_full", 32'(in_ready), 32'd0);
    res_ready = 1'b1;
    applyStimulus(3'd7, 4'd12, 1'b1, 1'b0);
    waitDrain(400);

    // N=0 completes one cycle after the pop with no start pulse.
    res_ready = 1'b0;
    applyStimulus(3'd0, 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("zero_res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    waitDrain(20);

    // Silent NSum: error completion after the full timeout, then normal service resumes.
    stubDead = 1'b1;
    applyStimulus(3'd3, 4'd0, 1'b0, 1'b1);
    waitSignal("timeout_issue", 10, 1'b0);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("timeout_latency", 32'(lat), 32'(TIMEOUT + 1));
    waitDrain(20);
    stubDead = 1'b0;
    applyStimulus(3'd2, 4'd3, 1'b0, 1'b0);
    waitDrain(40);

    // Reset during WAIT with a second request queued: nothing may come out afterwards.
    applyStimulus(3'd7, 4'd12, 1'b1, 1'b0);
    applyStimulus(3'd1, 4'd1, 1'b0, 1'b0);
    waitSignal("rstmid_issue", 10, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    expQ.delete();
    issueQ.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstmid_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rstmid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rstmid_res", 32'({res_sum, res_n, res_ovf, res_err}), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    checkOutput("rstmid_idle", 32'({res_valid, N_valid}), 32'd0);
    applyStimulus(3'd5, 4'd15, 1'b0, 1'b0);
    waitDrain(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
